// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key schedule controller. Drives an external single-round
// expansion step once per cycle and keeps all 11 round keys for random-access reads.
module aes_key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] exp_key_out,
  output logic [3:0]   exp_count,
  input  logic [127:0] exp_key_in,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         sched_done,
  output logic [1:0]   dbg_state
);

  localparam int         NUM_SLOTS = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_CNT  = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e       state_q;
  logic [3:0]   count_q;
  logic [127:0] cur_q;
  logic [127:0] slot_q [NUM_SLOTS];
  logic [127:0] rk_data_q;
  logic         sched_done_q;
  logic [127:0] rd_data_d;
  logic [3:0]   wr_idx_d;

  // Key handshake: a key transfers on a rising edge where key_valid && key_ready.
  // key_ready depends only on the state register; the source holds key_in until then.
  assign key_ready   = (state_q != S_EXPAND);
  assign busy        = (state_q == S_EXPAND);
  assign sched_done  = sched_done_q;
  assign exp_key_out = cur_q;
  assign exp_count   = count_q;
  assign rk_data     = rk_data_q;
  assign dbg_state   = state_q;
  assign wr_idx_d    = count_q + 4'd1;

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rk_addr == 4'(i)) rd_data_d = slot_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      cur_q        <= '0;
      rk_data_q    <= '0;
      sched_done_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      // Sampled from the pre-edge slot contents, so a same-edge write is not visible.
      rk_data_q <= rd_data_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (key_valid) begin
            slot_q[0]    <= key_in;
            cur_q        <= key_in;
            count_q      <= '0;
            sched_done_q <= 1'b0;
            state_q      <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          for (int i = 1; i < NUM_SLOTS; i++) begin
            if (wr_idx_d == 4'(i)) slot_q[i] <= exp_key_in;
          end
          cur_q <= exp_key_in;
          if (count_q == LAST_CNT) begin
            state_q      <= S_DONE;
            sched_done_q <= 1'b1;
          end else begin
            count_q <= wr_idx_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed bench for aes_key_schedule_ctrl with a behavioural AES-128 expansion
// step attached to the exp_key_out/exp_count/exp_key_in loop.
module tb_aes_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] exp_key_out;
  logic [3:0]   exp_count;
  logic [127:0] exp_key_in;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         busy;
  logic         sched_done;
  logic [1:0]   dbg_state;

  logic [2047:0] sbox_v = SBOX;
  logic [127:0]  fips_rk [11];
  logic [127:0]  zero_rk [11];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc;

  always #5 clk = ~clk;

  aes_key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .exp_key_out(exp_key_out), .exp_count(exp_count), .exp_key_in(exp_key_in),
    .rk_addr(rk_addr), .rk_data(rk_data), .busy(busy), .sched_done(sched_done),
    .dbg_state(dbg_state)
  );

  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_v[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] t, n0, n1, n2, n3;
    logic [7:0]  rc;
    case (r)
      4'd0: rc = 8'h01;  4'd1: rc = 8'h02;  4'd2: rc = 8'h04;  4'd3: rc = 8'h08;
      4'd4: rc = 8'h10;  4'd5: rc = 8'h20;  4'd6: rc = 8'h40;  4'd7: rc = 8'h80;
      4'd8: rc = 8'h1b;  4'd9: rc = 8'h36;  default: rc = 8'h00;
    endcase
    t  = {sb(k[23:16]) ^ rc, sb(k[15:8]), sb(k[7:0]), sb(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb exp_key_in = expand(exp_key_out, exp_count);

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (sched_done !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    chk("wait_done_timeout", {127'd0, sched_done}, 128'd1);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_addr = '0;
    fips_rk[0] = FIPS_KEY;
    zero_rk[0] = '0;
    for (int n = 1; n < 11; n++) begin
      fips_rk[n] = expand(fips_rk[n-1], 4'(n-1));
      zero_rk[n] = expand(zero_rk[n-1], 4'(n-1));
    end
    step(); step();
    chk("rst_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", sched_done, 0);
    chk("rst_rk_data", rk_data, 0);
    chk("rst_count", exp_count, 0);
    chk("rst_cur", exp_key_out, 0);
    chk("rst_state", dbg_state, 0);

    // FIPS-197 key: latency, exp_count progression and exp_key_out per round
    rst = 1'b0; key_in = FIPS_KEY; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_ready", key_ready, 0);
    chk("acc_count", exp_count, 0);
    chk("acc_cur", exp_key_out, fips_rk[0]);
    for (int n = 1; n < 10; n++) begin
      step();
      chk($sformatf("exp_count_%0d", n), exp_count, 128'(n));
      chk($sformatf("exp_key_out_%0d", n), exp_key_out, fips_rk[n]);
      chk($sformatf("not_done_%0d", n), sched_done, 0);
    end
    step();
    chk("done_at_10", sched_done, 1);
    chk("done_busy", busy, 0);
    chk("done_ready", key_ready, 1);
    chk("done_count", exp_count, 9);
    chk("done_cur", exp_key_out, fips_rk[10]);
    step();
    chk("done_count_hold", exp_count, 9);
    chk("done_hold", sched_done, 1);

    // Reverse read sweep, then out-of-range addresses
    for (int a = 10; a >= 0; a--) begin
      rk_addr = 4'(a);
      step();
      chk($sformatf("sweep_rk_%0d", a), rk_data, fips_rk[a]);
      if (a == 0) chk("fips_rk0", rk_data, FIPS_KEY);
      if (a == 1) chk("fips_rk1", rk_data, FIPS_RK1);
      if (a == 10) chk("fips_rk10", rk_data, FIPS_RK10);
    end
    for (int a = 11; a < 16; a++) begin
      rk_addr = 4'(a);
      step();
      chk($sformatf("oob_rk_%0d", a), rk_data, 0);
    end

    // Handshake: key A (all-zero) held, switched to B (FIPS) in cycle 3 of EXPAND
    key_in = '0; key_valid = 1'b1; rk_addr = 4'd10;
    step();
    chk("hs_busy", busy, 1);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("hs_ready_low_%0d", c + 1), key_ready, 0);
      if (c == 2) key_in = FIPS_KEY;
      step();
    end
    chk("hs_a_done", sched_done, 1);
    chk("hs_a_ready", key_ready, 1);
    chk("hs_a_last", exp_key_out, zero_rk[10]);
    chk("rbw_slot10_old", rk_data, fips_rk[10]);
    step();
    key_valid = 1'b0; rk_addr = 4'd3;
    chk("hs_b_done_drop", sched_done, 0);
    chk("hs_b_busy", busy, 1);
    chk("hs_b_cur", exp_key_out, FIPS_KEY);
    chk("hs_a_slot10", rk_data, zero_rk[10]);
    step(); step();
    chk("rbw_pre", rk_data, zero_rk[3]);
    step();
    chk("rbw_old", rk_data, zero_rk[3]);
    step();
    chk("rbw_new", rk_data, fips_rk[3]);
    wait_done(20, cyc);
    chk("hs_b_latency", 128'(cyc), 6);
    for (int a = 0; a < 11; a++) begin
      rk_addr = 4'(a);
      step();
      chk($sformatf("hs_b_rk_%0d", a), rk_data, fips_rk[a]);
    end

    // Reset in cycle 5 of EXPAND aborts; rst beats a simultaneous key_valid
    key_in = '0; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; key_valid = 1'b1; key_in = FIPS_KEY;
    step();
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_ready", key_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", sched_done, 0);
    chk("mid_rst_count", exp_count, 0);
    step();
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_cur", exp_key_out, 0);
    rst = 1'b0; key_valid = 1'b0;
    for (int a = 0; a < 11; a++) begin
      rk_addr = 4'(a);
      step();
      chk($sformatf("post_rst_rk_%0d", a), rk_data, 0);
    end
    chk("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
